// File: rtl/fft_pkg.sv
// Shared constants, FSM states, result record and magnitude helper for the FFT bin sequencer.
// Latency: not applicable (declarations and a combinational helper only).
// Backpressure: not applicable.
package fft_pkg;

    localparam int DW  = 9;       // signed width of FFT real/imag outputs
    localparam int NPT = 8;       // bins per sweep
    localparam int BW  = 3;       // bin index width
    localparam int MW  = DW + 1;  // unsigned L1 magnitude width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One captured bin as it travels through the result buffer
    typedef struct packed {
        logic        [BW-1:0] bin;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic        [MW-1:0] mag;
    } res_t;

    // |re|+|im|; abs is taken at DW+1 bits so the most negative input (-256) becomes +256,
    // and the sum of two such values (512) still fits in MW bits without saturation.
    function automatic logic [MW-1:0] l1_mag(input logic signed [DW-1:0] re,
                                             input logic signed [DW-1:0] im);
        logic signed [DW:0] re_x;
        logic signed [DW:0] im_x;
        logic        [DW:0] re_a;
        logic        [DW:0] im_a;
        re_x = {re[DW-1], re};
        im_x = {im[DW-1], im};
        re_a = re_x[DW] ? -re_x : re_x;
        im_a = im_x[DW] ? -im_x : im_x;
        return re_a + im_a;
    endfunction

endpackage

// File: rtl/fft_res_fifo.sv
// Generic synchronous FIFO with occupancy count, full and empty flags.
// Latency: a written entry is visible at the head one clock after the write; head is read combinationally.
// Backpressure: writes are dropped when full and reads ignored when empty; the producer must honour full/count.
module fft_res_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rptr];

    // Storage array; contents need no reset because empty gates every consumer
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_bin_sequencer.sv
// Sweeps the FFT core's bin select 0..NPT-1, captures each bin with its tag and L1 magnitude, tracks the peak bin.
// Latency: start sampled at edge E0 -> first beat valid after E2; with m_ready held high, beats are back-to-back.
// Backpressure: full valid/ready; issue is credit-gated on FIFO occupancy plus in-flight bins, so nothing drops.
module fft_bin_sequencer
    import fft_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [BW-1:0]        sel,
    input  logic signed [DW-1:0] yr,
    input  logic signed [DW-1:0] yi,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BW-1:0]        m_bin,
    output logic signed [DW-1:0] m_re,
    output logic signed [DW-1:0] m_im,
    output logic [MW-1:0]        m_mag,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic [BW-1:0]        peak_bin,
    output logic [MW-1:0]        peak_mag
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]   LAST_BIN = BW'(NPT - 1);
    localparam logic [CW:0]     DEPTH_C  = (CW+1)'(FIFO_DEPTH);

    state_t          state;
    logic [BW-1:0]   k;
    logic [BW-1:0]   issue_bin;
    logic            issue;
    logic            credit_ok;
    logic            p1_vld;
    logic            p2_vld;
    logic [BW-1:0]   p1_bin;
    logic [BW-1:0]   p2_bin;
    logic [1:0]      in_flight;
    logic [CW:0]     occ_sum;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    res_t            wr_dat;
    res_t            head;
    logic            hs_last;

    // Credit: bins already issued but not yet in the FIFO still need a slot reserved
    assign in_flight = {1'b0, p1_vld} + {1'b0, p2_vld};
    assign occ_sum   = {1'b0, fifo_cnt} + {{(CW-1){1'b0}}, in_flight};
    assign credit_ok = !fifo_full && (occ_sum < DEPTH_C);

    // Bin 0 goes out on the start edge itself (pipeline and FIFO are empty in IDLE)
    assign issue     = ((state == IDLE) && start) || ((state == SWEEP) && credit_ok);
    assign issue_bin = (state == IDLE) ? '0 : k;

    assign busy    = (state != IDLE);
    assign m_valid = !fifo_empty;
    assign m_bin   = m_valid ? head.bin : '0;
    assign m_re    = m_valid ? head.re  : '0;
    assign m_im    = m_valid ? head.im  : '0;
    assign m_mag   = m_valid ? head.mag : '0;
    assign m_last  = m_valid && (head.bin == LAST_BIN);
    assign hs_last = m_valid && m_ready && m_last;

    // Record written when the tag from two issues ago meets the core's registered output
    always_comb begin
        wr_dat     = '0;
        wr_dat.bin = p2_bin;
        wr_dat.re  = yr;
        wr_dat.im  = yi;
        wr_dat.mag = l1_mag(yr, yi);
    end

    fft_res_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (p2_vld),
        .wr_dat (wr_dat),
        .rd_rdy (m_ready),
        .rd_dat (head),
        .count  (fifo_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sweep control: IDLE -> SWEEP on start, SWEEP -> DRAIN after the last issue, DRAIN -> IDLE on last handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (issue && (issue_bin == LAST_BIN)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bin issue and the two-stage tag pipeline that tracks the core's one-cycle output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k      <= '0;
            sel    <= '0;
            p1_vld <= 1'b0;
            p1_bin <= '0;
            p2_vld <= 1'b0;
            p2_bin <= '0;
        end else begin
            p1_vld <= issue;
            p2_vld <= p1_vld;
            p2_bin <= p1_bin;
            if (issue) begin
                sel    <= issue_bin;
                k      <= issue_bin + 1'b1;
                p1_bin <= issue_bin;
            end
        end
    end

    // Peak tracking at FIFO write: strictly-greater replaces, so ties keep the earlier bin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if ((state == IDLE) && start) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (p2_vld && ((p2_bin == '0) || (wr_dat.mag > peak_mag))) begin
            peak_bin <= p2_bin;
            peak_mag <= wr_dat.mag;
        end
    end

endmodule

// File: tb/tb_fft_bin_sequencer.sv
// Directed bench for fft_bin_sequencer with a one-cycle FFT core stub and an expected-beat queue.
// Latency: checks first beat two cycles after the start edge and done one cycle after the last handshake.
// Backpressure: exercises a 10-cycle m_ready stall, checking hold stability and credit-limited issue.
module tb_fft_bin_sequencer;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        sel;
    logic signed [8:0] yr;
    logic signed [8:0] yi;
    logic              m_valid;
    logic              m_ready;
    logic [2:0]        m_bin;
    logic signed [8:0] m_re;
    logic signed [8:0] m_im;
    logic [9:0]        m_mag;
    logic              m_last;
    logic              busy;
    logic              done;
    logic [2:0]        peak_bin;
    logic [9:0]        peak_mag;

    typedef struct {
        int bin;
        int re;
        int im;
        int mag;
    } exp_t;

    exp_t sb[$];
    int   mode;
    int   n_chk;
    int   n_fail;

    fft_bin_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .yr       (yr),
        .yi       (yi),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_bin    (m_bin),
        .m_re     (m_re),
        .m_im     (m_im),
        .m_mag    (m_mag),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .peak_bin (peak_bin),
        .peak_mag (peak_mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub data: mode 0 nominal, mode 1 forces -256/-256 on bin 3, mode 2 gives bins 2 and 5 magnitude 100
    function automatic int f_re(input int md, input int b);
        if (md == 1 && b == 3) return -256;
        if (md == 2 && b == 2) return 60;
        if (md == 2 && b == 5) return -50;
        return 10 * b;
    endfunction

    function automatic int f_im(input int md, input int b);
        if (md == 1 && b == 3) return -256;
        if (md == 2 && b == 2) return -40;
        if (md == 2 && b == 5) return 50;
        return -3 * b;
    endfunction

    // FFT core stub: output registered one clock after sel
    always @(posedge clk) begin
        yr <= 9'(f_re(mode, int'(sel)));
        yi <= 9'(f_im(mode, int'(sel)));
    end

    function automatic exp_t model(input int md, input int b);
        exp_t e;
        e.bin = b;
        e.re  = f_re(md, b);
        e.im  = f_im(md, b);
        e.mag = (e.re < 0 ? -e.re : e.re) + (e.im < 0 ? -e.im : e.im);
        return e;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sweep(input int md, input int stall, input int restart_at, input int abort_at,
                         input int exp_pb, input int exp_pm);
        int          beats;
        int          dones;
        int          lat;
        int          last_hs;
        int          stall_left;
        bit          seen_v;
        logic [32:0] held;
        exp_t        e;
        beats = 0; dones = 0; lat = -1; last_hs = -100; stall_left = 0; seen_v = 0; held = '0;
        mode = md;
        sb.delete();
        for (int b = 0; b < 8; b++) sb.push_back(model(md, b));
        @(negedge clk);
        start   = 1'b1;
        m_ready = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (abort_at > 0 && beats == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_async_zero", {sel, m_valid, m_bin, m_re, m_im, m_mag, m_last, busy, done,
                                       peak_bin, peak_mag}, 0);
                @(negedge clk);
                rst     = 1'b0;
                m_ready = 1'b1;
                @(negedge clk);
                chk("rst_flush_mvalid", m_valid, 0);
                chk("rst_flush_busy", busy, 0);
                sb.delete();
                return;
            end
            if (!seen_v && m_valid) begin
                seen_v = 1;
                lat    = cyc;
                held   = {m_valid, m_bin, m_re, m_im, m_mag, m_last};
                if (stall > 0) begin
                    stall_left = stall - 1;
                    m_ready    = 1'b0;
                end
            end else if (stall_left > 0) begin
                m_ready = 1'b0;
                chk("stall_hold", {m_valid, m_bin, m_re, m_im, m_mag, m_last}, held);
                stall_left--;
                if (stall_left == 0) chk("stall_credit_sel", sel, 3);
            end else begin
                m_ready = 1'b1;
            end
            if (done) begin
                dones++;
                chk("done_after_last", cyc, last_hs + 1);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", beats, 8);
                end else begin
                    e = sb.pop_front();
                    chk("beat_bin", m_bin, e.bin);
                    chk("beat_re", $signed(m_re), e.re);
                    chk("beat_im", $signed(m_im), e.im);
                    chk("beat_mag", m_mag, e.mag);
                    chk("beat_last", m_last, (e.bin == 7) ? 1 : 0);
                end
                beats++;
                if (m_last) last_hs = cyc;
            end
            if (dones > 0 && cyc > last_hs + 4) break;
        end
        chk("beat_count", beats, 8);
        chk("done_count", dones, 1);
        chk("first_valid_latency", lat, 3);
        chk("queue_empty", sb.size(), 0);
        chk("peak_bin", peak_bin, exp_pb);
        chk("peak_mag", peak_mag, exp_pm);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        mode    = 0;
        rst     = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {sel, m_valid, m_bin, m_re, m_im, m_mag, m_last, busy, done,
                              peak_bin, peak_mag}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_mvalid", m_valid, 0);
        chk("post_reset_busy", busy, 0);

        // Nominal sweep with m_ready held high
        sweep(0, 0, -1, 0, 7, 91);
        // Ten-cycle stall starting at the first beat
        sweep(0, 10, -1, 0, 7, 91);
        // Most negative inputs on bin 3
        sweep(1, 0, -1, 0, 3, 512);
        // Tie between bins 2 and 5, plus a start pulse while busy
        sweep(2, 0, 4, 0, 2, 100);
        // Reset after three beats of a sweep, then a fresh sweep
        sweep(1, 0, -1, 3, 0, 0);
        sweep(0, 0, -1, 0, 7, 91);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
